// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter sharing one PIPO register between N_REQ requesters.
// Grants, pulses load, holds, verifies readback, then acks the owner.
module pipo_load_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         ack,
    output logic                     busy,
    output logic                     load,
    output logic [WIDTH-1:0]         parallel_in,
    input  logic [WIDTH-1:0]         parallel_out,
    output logic                     mismatch
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PW:0]      NQ   = (PW+1)'(N_REQ);
    localparam logic [PW:0]      INC  = (PW+1)'(1);
    localparam logic [CW-1:0]    LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [N_REQ-1:0] ONE  = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [PW-1:0]     pick;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              load_q, load_d;
    logic              busy_q, busy_d;
    logic              mm_q, mm_d;
    logic [WIDTH-1:0]  pin_q, pin_d;
    logic [WIDTH-1:0]  pick_data;
    logic              found;
    logic [PW:0]       sum;
    logic [PW:0]       win_inc;

    // Search from ptr upward, wrapping at N_REQ
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= NQ) sum = sum - NQ;
            if (!found && req[sum[PW-1:0]]) begin
                found = 1'b1;
                pick  = sum[PW-1:0];
            end
        end
    end

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == PW'(i)) pick_data = req_data[i*WIDTH +: WIDTH];
        end
    end

    assign win_inc = {1'b0, win_q} + INC;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ack_d   = '0;
        load_d  = 1'b0;
        busy_d  = busy_q;
        mm_d    = mm_q;
        pin_d   = pin_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    grant_d = ONE << pick;
                    pin_d   = pick_data;
                    load_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = HOLD;
            end
            HOLD: begin
                // Register has captured parallel_in by the first hold cycle
                if (cnt_q == '0 && parallel_out != pin_q) mm_d = 1'b1;
                if (cnt_q == LAST) begin
                    grant_d = '0;
                    ack_d   = grant_q;
                    ptr_d   = (win_inc >= NQ) ? '0 : win_inc[PW-1:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                pin_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            mm_q    <= 1'b0;
            pin_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            mm_q    <= mm_d;
            pin_q   <= pin_d;
        end
    end

    assign grant       = grant_q;
    assign ack         = ack_q;
    assign busy        = busy_q;
    assign load        = load_q;
    assign parallel_in = pin_q;
    assign mismatch    = mm_q;

endmodule

// File: doc/pipo_load_arbiter.md
Name: pipo_load_arbiter

Overview:
Round-robin arbiter that shares one W-bit PIPO register (ports load/parallel_in/parallel_out) between N requesters. It grants one requester at a time and drives a single-cycle load pulse with that requester's data. It then holds the register value stable for HOLD_CYCLES cycles, checks the readback, and acknowledges the requester. It sits between requester logic and the pipo_shift_register instance, and owns that instance's load and parallel_in pins.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 4, data width of the shared PIPO register
HOLD_CYCLES, 3, cycles the loaded value is held before ack (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req  input  N_REQ  request per requester; held high until its ack
req_data  input  N_REQ*WIDTH  requester i's data at bits [i*WIDTH +: WIDTH]
grant  output  N_REQ  one-hot current owner; 0 when idle
ack  output  N_REQ  one-cycle one-hot completion pulse to owner
busy  output  1  high in any state other than IDLE
load  output  1  to PIPO load; high exactly one cycle per grant
parallel_in  output  WIDTH  to PIPO parallel_in; winner's data latched at grant
parallel_out  input  WIDTH  from PIPO parallel_out, used for readback check
mismatch  output  1  sticky readback error flag

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a rising edge):
  - state=IDLE, ptr=0, hold counter=0.
  - grant, ack, load, parallel_in, busy and mismatch are all 0.
  - Reset wins over every other event, including a reset mid-transaction. An aborted transaction never produces an ack.
- States: IDLE, LOAD, HOLD, DONE.
- IDLE:
  - If req is non-zero, pick the winner by searching from index ptr upward with wrap-around.
  - At the edge: grant<=onehot(winner), parallel_in<=req_data slice of winner, load<=1, busy<=1, go to LOAD.
  - If req is 0, stay in IDLE with outputs at 0.
- LOAD:
  - load is high for this one cycle; the PIPO captures parallel_in at the edge ending it.
  - At that edge: load<=0, counter<=0, go to HOLD.
- HOLD:
  - Lasts exactly HOLD_CYCLES cycles.
  - parallel_in and grant stay stable; load stays 0.
  - In the first HOLD cycle, if parallel_out != parallel_in, set mismatch<=1. mismatch stays set until rst.
  - On the last HOLD cycle: grant<=0, ack<=onehot(winner), ptr<=(winner+1) mod N_REQ, go to DONE.
- DONE:
  - ack is high for this cycle only. No arbitration happens in DONE.
  - At the edge: ack<=0, busy<=0, go to IDLE.
  - Requesters deassert req at the edge ending DONE, so IDLE never sees a stale req.
- Timing, with req sampled at edge E0:
  - load is high in cycle 1.
  - HOLD covers cycles 2..HOLD_CYCLES+1.
  - ack is in cycle HOLD_CYCLES+2.
  - The next grant is possible at the earliest in cycle HOLD_CYCLES+4 (IDLE cycle, then load).
- Boundary rules:
  - A req deasserted during LOAD or HOLD does not abort; the transaction completes and acks.
  - New reqs arriving during a transaction wait; no request is dropped.
  - Only one grant is active at a time.
  - ptr wraps from N_REQ-1 to 0.
  - With a single requester continuously re-requesting, that requester wins every round.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=1111 -> grant=0000, load=0, ack=0, busy=0, mismatch=0. After release, the first grant is 0001 (ptr=0).
2. Single request: req=0001, data0=1010 -> cycle 1: load=1, parallel_in=1010, grant=0001. parallel_out=1010 from cycle 2. ack=0001 in cycle 5 (HOLD_CYCLES=3). mismatch=0.
3. All request, data 1010/0101/1100/0011, each dropping req after its own ack -> grants 0001, 0010, 0100, 1000 in order. parallel_out sequence 1010, 0101, 1100, 0011. Exactly 4 load pulses.
4. Fairness: req[0] and req[2] re-asserted in the IDLE cycle after each ack -> grant order 0, 2, 0, 2. Neither requester is granted twice in a row.
5. Reset mid-HOLD: rst=1 during the 2nd HOLD cycle -> grant, load, busy return to 0 the next cycle. No ack is issued. The next request is arbitrated from ptr=0.
6. Readback error: bench PIPO model with parallel_out stuck at 0000, data0=0110 -> mismatch=1 from the cycle after the first HOLD cycle. It stays 1 through later clean transactions until rst.
